pci_arbiter: RTL

Central bus arbiter for the PCI segment. It shares the bus among `N` initiators using round-robin priority over their active-low `req`/`gnt` pairs. It watches `frame` and `irdy` to track when the bus is busy, and removes a grant when the granted master fails to start a transaction in time. It drives the `gnt` input of every initiator's per-device state machine. It parks the bus on a default master when nobody is requesting.

---
 rtl/pci_arbiter_pkg.sv | 6 +
 rtl/pci_arbiter_rr_pick.sv | 29 ++
 rtl/pci_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/pci_arbiter_pkg.sv
// pci_arb_pkg: arbiter state encoding and default parameter values
package pci_arb_pkg;
   typedef enum logic [1:0] {GAP, PARK, GRANT, BUSY} arb_state_t;
   localparam int PARK_ID_DEF = 0;
   localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// pci_rr_pick: round-robin request picker, searches base+1 .. base (base last)
//   req    : active-low requests
//   base   : index of the current owner
//   winner : first requester after base, base itself when nothing requests
//   valid  : some request is low
module pci_rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] base,
   output logic [W-1:0] winner,
   output logic         valid
);
   logic [W-1:0] idx;
   // Descending scan: the last hit written is the closest index after base.
   always_comb begin
      valid  = 1'b0;
      winner = base;
      idx    = '0;
      for (int i = N; i >= 1; i--) begin
         idx = W'((int'(base) + i) % N);
         if (!req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end
endmodule

// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI bus arbiter with parking and grant timeout
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : active-low requests, one per initiator
//   frame, irdy  : bus FRAME# / IRDY#, active-low
//   gnt          : active-low registered grants, at most one low
//   owner        : current or last granted master
//   bus_busy     : registered, high while a transaction runs
//   timeout      : one-cycle pulse when an unused grant is withdrawn
module pci_arbiter
   import pci_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int PARK_ID = PARK_ID_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 frame,
   input  logic                 irdy,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] owner,
   output logic                 bus_busy,
   output logic                 timeout
);
   localparam int W  = $clog2(N);
   localparam int CW = $clog2(TIMEOUT);
   arb_state_t   state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  winner;
   logic          valid;
   pci_rr_pick #(.N(N), .W(W)) u_pick (
      .req    (req),
      .base   (owner),
      .winner (winner),
      .valid  (valid)
   );
   // owner keeps its value through GAP/PARK, so the first park after reset
   // lands on PARK_ID and a timed-out owner stays the search base.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= GAP;
         owner    <= W'(PARK_ID);
         gnt      <= '1;
         bus_busy <= 1'b0;
         timeout  <= 1'b0;
         cnt      <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            GAP:
               if (valid) begin
                  state <= GRANT;
                  owner <= winner;
                  cnt   <= '0;
                  gnt   <= ~(N'(1) << winner);
               end else begin
                  state <= PARK;
                  gnt   <= ~(N'(1) << owner);
               end
            PARK:
               if (!frame) begin
                  state    <= BUSY;
                  bus_busy <= 1'b1;
               end else if (valid && winner == owner) begin
                  state <= GRANT;
                  cnt   <= '0;
               end else if (valid) begin
                  state <= GAP;
                  gnt   <= '1;
               end
            GRANT:
               if (!frame) begin
                  state    <= BUSY;
                  bus_busy <= 1'b1;
               end else if (req[owner] || cnt == CW'(TIMEOUT - 1)) begin
                  state   <= GAP;
                  gnt     <= '1;
                  timeout <= !req[owner];
               end else begin
                  cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
               end
            BUSY:
               if (frame && irdy) begin
                  bus_busy <= 1'b0;
                  if (!valid) begin
                     state <= PARK;
                  end else if (winner == owner) begin
                     state <= GRANT;
                     cnt   <= '0;
                  end else begin
                     state <= GAP;
                     gnt   <= '1;
                  end
               end
            default: state <= GAP;
         endcase
      end
   end
endmodule
